// File: rtl/ej1b_arbiter_if.sv
// Requester, shared-FSM and response signals of ej1b_arbiter bundled as one port.
// master is the requester/FSM side, slave is the arbiter.
interface ej1b_arbiter_if #(parameter int LEN_W = 3);
  logic             req0;
  logic             req1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             i0;
  logic             s0;
  logic             i1;
  logic             s1;
  logic             fsm_i;
  logic             fsm_s;
  logic             fsm_b1;
  logic             fsm_b2;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             rsp_valid;
  logic             rsp_id;
  logic             rsp_b1;
  logic             rsp_b2;

  modport master (
    output req0, req1, len0, len1, i0, s0, i1, s1, fsm_b1, fsm_b2,
    input  fsm_i, fsm_s, gnt0, gnt1, busy, rsp_valid, rsp_id, rsp_b1, rsp_b2
  );

  modport slave (
    input  req0, req1, len0, len1, i0, s0, i1, s1, fsm_b1, fsm_b2,
    output fsm_i, fsm_s, gnt0, gnt1, busy, rsp_valid, rsp_id, rsp_b1, rsp_b2
  );
endinterface

// File: rtl/ej1b_arbiter.sv
// Round-robin two-requester arbiter lending one shared ej1b FSM for len+1 cycles,
// then waiting FSM_LAT settle cycles and pulsing the captured B1/B2 back to the owner.
module ej1b_arbiter #(
  parameter int LEN_W   = 3,
  parameter int FSM_LAT = 1
) (
  input logic           clk,
  input logic           rst_n,
  ej1b_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT, RESP} state_t;

  localparam logic [1:0] LAT_LAST = (FSM_LAT > 0) ? 2'(FSM_LAT - 1) : 2'd0;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       lat_cnt;
  logic             owner;
  logic             ptr;
  logic             held_i;
  logic             held_s;
  logic             cap_b1;
  logic             cap_b2;
  logic             any_req;
  logic             winner;
  logic             run_i;
  logic             run_s;
  logic             run_done;
  logic             wait_done;
  logic             gnt0;
  logic             gnt1;
  logic             fsm_i;
  logic             fsm_s;
  logic             rsp_valid;
  logic             rsp_id;

  assign any_req   = bus.req0 | bus.req1;
  // A lone requester always wins; on a tie the one that did not own the last burst wins.
  assign winner    = (bus.req0 & bus.req1) ? ~ptr : bus.req1;
  assign run_i     = owner ? bus.i1 : bus.i0;
  assign run_s     = owner ? bus.s1 : bus.s0;
  assign run_done  = (cnt == '0);
  assign wait_done = (lat_cnt == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    fsm_i     = 1'b0;
    fsm_s     = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = RUN;
      end
      RUN: begin
        gnt0  = ~owner;
        gnt1  = owner;
        fsm_i = run_i;
        fsm_s = run_s;
        if (run_done) state_nxt = (FSM_LAT > 0) ? WAIT : RESP;
      end
      WAIT: begin
        fsm_i = held_i;
        fsm_s = held_s;
        if (wait_done) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      lat_cnt <= 2'd0;
      owner   <= 1'b0;
      ptr     <= 1'b1;
      held_i  <= 1'b0;
      held_s  <= 1'b0;
      cap_b1  <= 1'b0;
      cap_b2  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cnt   <= winner ? bus.len1 : bus.len0;
            owner <= winner;
            ptr   <= winner;
          end
        end
        RUN: begin
          // The last RUN-cycle drive is what WAIT keeps presenting to the FSM.
          held_i <= run_i;
          held_s <= run_s;
          if (run_done) begin
            lat_cnt <= LAT_LAST;
            if (FSM_LAT == 0) begin
              cap_b1 <= bus.fsm_b1;
              cap_b2 <= bus.fsm_b2;
            end
          end else begin
            cnt <= cnt - LEN_W'(1);
          end
        end
        WAIT: begin
          if (wait_done) begin
            cap_b1 <= bus.fsm_b1;
            cap_b2 <= bus.fsm_b2;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.fsm_i     = fsm_i;
  assign bus.fsm_s     = fsm_s;
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_b1    = cap_b1;
  assign bus.rsp_b2    = cap_b2;
endmodule

// File: doc/ej1b_arbiter.md
EJ1B_ARBITER -- requirements
Module: ej1b_arbiter

Interface
REQ-001 Parameter LEN_W, default 3: width of the burst-length inputs.
REQ-002 Parameter FSM_LAT, default 1, legal range 0..3: settle cycles between the last driven burst cycle and result capture.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1  burst request from requester 0 / 1, level-sensitive.
REQ-006 len0, len1  input  LEN_W  burst length minus one for requester 0 / 1.
REQ-007 i0, s0, i1, s1  input  1  per-requester I/S stimulus for the shared FSM.
REQ-008 fsm_i, fsm_s  output  1  I and S drive to the shared ej1b FSM.
REQ-009 fsm_b1, fsm_b2  input  1  B1/B2 outputs returned by the shared FSM.
REQ-010 gnt0, gnt1  output  1  grant to requester 0 / 1; one-hot or zero.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 rsp_valid, rsp_id, rsp_b1, rsp_b2  output  1 each  one-cycle result pulse, owning requester, captured B1/B2.

Function
REQ-013 The FSM shall have states IDLE, RUN, WAIT and RESP.
REQ-014 IDLE: at an edge with any req high, go to RUN, load cnt with the winner's len, and latch the winner as owner.
REQ-015 Arbitration shall be round-robin on a last-owner pointer; on a tie, the requester that is not last-owner wins; the pointer resets to 1 so that req0 wins the first tie.
REQ-016 A single requesting input shall win regardless of the pointer; the pointer updates on every grant.
REQ-017 RUN: gnt of the owner is high, and fsm_i/fsm_s follow the owner's i/s combinationally.
REQ-018 RUN shall last exactly len+1 cycles (len=0 gives 1 cycle, len=7 gives 8 cycles); cnt decrements each edge.
REQ-019 On leaving RUN, go to WAIT if FSM_LAT>0, else go to RESP.
REQ-020 WAIT: gnt low; fsm_i/fsm_s hold the last RUN-cycle values from a register; lasts exactly FSM_LAT cycles.
REQ-021 fsm_b1/fsm_b2 shall be captured on the edge that leaves RUN (FSM_LAT=0) or leaves WAIT (FSM_LAT>0).
REQ-022 RESP: for exactly one cycle, rsp_valid=1, rsp_id=owner, and rsp_b1/rsp_b2 carry the captured values; then return to IDLE.
REQ-023 Outside RESP, rsp_valid=0 and rsp_b1/rsp_b2 hold their last captured values.
REQ-024 In IDLE and RESP, fsm_i=fsm_s=0 and gnt0=gnt1=0.
REQ-025 A requester dropping req during RUN or WAIT shall not abort the burst; its i/s are still forwarded.
REQ-026 len changing after grant shall have no effect.
REQ-027 Requests arriving during RUN, WAIT or RESP shall be evaluated only in IDLE, so at least one IDLE cycle separates bursts.
REQ-028 gnt0 and gnt1 shall never be high in the same cycle.

Reset
REQ-029 rst_n low shall immediately, with no clock, force: state IDLE; pointer 1; cnt 0; and gnt0, gnt1, fsm_i, fsm_s, busy, rsp_valid, rsp_id, rsp_b1, rsp_b2 all 0.
REQ-030 Reset asserted mid-RUN shall abandon the burst with no RESP pulse; the first edge after release samples requests from IDLE.

Verification
REQ-031 Single burst, FSM_LAT=1: req0=1, len0=2, i0=1, s0=0 -> gnt0 high 3 cycles with fsm_i=1, fsm_s=0; 1 WAIT cycle; rsp_valid 1 cycle with rsp_id=0 and rsp_b1/b2 equal to fsm_b1/b2 at the WAIT exit edge.
REQ-032 Tie after reset: req0=req1=1, len0=len1=0 -> grants in order gnt0, gnt1, gnt0, gnt1, each burst 1 cycle, separated by WAIT, RESP and IDLE cycles.
REQ-033 Length boundary: len1=7 alone -> gnt1 high exactly 8 cycles; busy high from the first grant cycle through RESP inclusive.
REQ-034 Request drop: req0 falls in the first RUN cycle with len0=3 -> gnt0 still high 4 cycles and a RESP pulse still occurs.
REQ-035 Reset mid-burst: rst_n low in the 2nd RUN cycle -> all outputs 0 asynchronously; no rsp_valid; after release, a tie grants req0.
REQ-036 FSM_LAT=0: fsm_b1=1, fsm_b2=0 on the last RUN edge -> RESP directly follows RUN, with rsp_b1=1 and rsp_b2=0.
